sprite_line_sched: RTL and testbench

- Per-scanline sprite fetch scheduler. Sits between the 1024x768 display timing generator and the shared sprite-pixel memory port.
- At the end of each active line it scans the sprite attribute table and finds the sprites that intersect the next line.
- For each hit it issues a valid/ready fetch request, up to MAX_PER_LINE requests per line, so the line buffer is filled during horizontal blanking.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_line_sched_if.sv | 13 +
 rtl/sprite_hit_check.sv | 19 +
 rtl/sprite_line_sched.sv | 125 ++++++++++++
 tb/tb_sprite_line_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and sizing for the sprite line scheduler and pixel compositor.
package sprite_pkg;

  localparam int NUM_SPR      = 8;
  localparam int MAX_PER_LINE = 4;
  localparam int SPR_H        = 16;
  localparam int CORDW        = 12;
  localparam int V_ACTIVE     = 768;

  localparam int SPR_IDXW = $clog2(NUM_SPR);
  localparam int ROWW     = $clog2(SPR_H);
  localparam int CNTW     = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN_ADDR,
    SCAN_CHK,
    ISSUE,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [SPR_IDXW-1:0] spr;
    logic [ROWW-1:0]     row;
  } spr_req_t;

endpackage

// File: rtl/sprite_line_sched_if.sv
// Sprite fetch request channel: valid/ready handshake carrying sprite index and row.
interface sprite_line_sched_if;
  import sprite_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [SPR_IDXW-1:0] req_spr;
  logic [ROWW-1:0]     req_row;

  modport master (output req_valid, req_spr, req_row, input req_ready);
  modport slave  (input req_valid, req_spr, req_row, output req_ready);

endinterface

// File: rtl/sprite_hit_check.sv
// Combinational test of whether a sprite covers a target line, and which sprite row that is.
module sprite_hit_check
  import sprite_pkg::*;
(
  input  logic [CORDW-1:0] tgt,
  input  logic [CORDW-1:0] attr_y,
  input  logic             attr_vis,
  output logic             hit,
  output logic [ROWW-1:0]  row
);

  // One extra bit so the MSB acts as a borrow: set when the sprite starts below tgt.
  logic [CORDW:0] diff;

  assign diff = {1'b0, tgt} - {1'b0, attr_y};
  assign hit  = attr_vis && !diff[CORDW] && (diff < (CORDW+1)'(SPR_H));
  assign row  = diff[ROWW-1:0];

endmodule

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite fetch scheduler: scans the attribute table on each de falling edge
// and issues up to MAX_PER_LINE fetch requests. Define SPRITE_SCAN_REV_EN for a descending scan.
module sprite_line_sched
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [CORDW-1:0]    sy,
  input  logic                de,
  output logic [SPR_IDXW-1:0] attr_idx,
  input  logic [CORDW-1:0]    attr_y,
  input  logic                attr_vis,
  sprite_line_sched_if.master req,
  output logic                line_done,
  output logic                overflow,
  output logic                late_err
);

  sched_state_t        state;
  logic                de_q;
  logic [CORDW-1:0]    tgt;
  logic [SPR_IDXW-1:0] idx;
  logic [SPR_IDXW-1:0] idx_next;
  logic [CNTW-1:0]     count;
  logic                ovf_line;
  logic                req_valid_q;
  spr_req_t            req_q;

  logic                trig;
  logic [CORDW-1:0]    tgt_next;
  logic                hit;
  logic [ROWW-1:0]     row;

`ifdef SPRITE_SCAN_REV_EN
  localparam logic [SPR_IDXW-1:0] IDX_FIRST = SPR_IDXW'(NUM_SPR - 1);
  localparam logic [SPR_IDXW-1:0] IDX_LAST  = '0;
  assign idx_next = idx - 1'b1;
`else
  localparam logic [SPR_IDXW-1:0] IDX_FIRST = '0;
  localparam logic [SPR_IDXW-1:0] IDX_LAST  = SPR_IDXW'(NUM_SPR - 1);
  assign idx_next = idx + 1'b1;
`endif

  assign trig     = de_q && !de;
  assign tgt_next = (sy == CORDW'(V_ACTIVE - 1)) ? '0 : sy + 1'b1;

  sprite_hit_check u_hit (
    .tgt      (tgt),
    .attr_y   (attr_y),
    .attr_vis (attr_vis),
    .hit      (hit),
    .row      (row)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      de_q        <= 1'b0;
      tgt         <= '0;
      idx         <= '0;
      count       <= '0;
      ovf_line    <= 1'b0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
      line_done   <= 1'b0;
      overflow    <= 1'b0;
      late_err    <= 1'b0;
    end else begin
      de_q      <= de;
      line_done <= 1'b0;
      // A trigger that lands mid-scan is reported but never disturbs the scan in progress.
      late_err  <= trig && (state != IDLE);
      case (state)
        IDLE: begin
          if (trig) begin
            tgt      <= tgt_next;
            idx      <= IDX_FIRST;
            count    <= '0;
            ovf_line <= 1'b0;
            state    <= SCAN_ADDR;
          end
        end
        SCAN_ADDR: state <= SCAN_CHK;
        SCAN_CHK: begin
          if (hit && (count < CNTW'(MAX_PER_LINE))) begin
            req_valid_q <= 1'b1;
            req_q.spr   <= idx;
            req_q.row   <= row;
            state       <= ISSUE;
          end else begin
            if (hit) ovf_line <= 1'b1;
            if (idx == IDX_LAST) state <= DONE;
            else begin
              idx   <= idx_next;
              state <= SCAN_ADDR;
            end
          end
        end
        ISSUE: begin
          if (req.req_ready) begin
            req_valid_q <= 1'b0;
            count       <= count + 1'b1;
            if (idx == IDX_LAST) state <= DONE;
            else begin
              idx   <= idx_next;
              state <= SCAN_ADDR;
            end
          end
        end
        DONE: begin
          line_done <= 1'b1;
          overflow  <= ovf_line;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign attr_idx      = idx;
  assign req.req_valid = req_valid_q;
  assign req.req_spr   = req_q.spr;
  assign req.req_row   = req_q.row;

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched with a request scoreboard and a registered attribute table model.
module tb_sprite_line_sched;
  import sprite_pkg::*;

  logic                clk;
  logic                reset;
  logic [CORDW-1:0]    sy;
  logic                de;
  logic [SPR_IDXW-1:0] attr_idx;
  logic [CORDW-1:0]    attr_y;
  logic                attr_vis;
  logic                line_done;
  logic                overflow;
  logic                late_err;

  sprite_line_sched_if rq ();

  sprite_line_sched dut (
    .clk       (clk),
    .reset     (reset),
    .sy        (sy),
    .de        (de),
    .attr_idx  (attr_idx),
    .attr_y    (attr_y),
    .attr_vis  (attr_vis),
    .req       (rq),
    .line_done (line_done),
    .overflow  (overflow),
    .late_err  (late_err)
  );

  logic [CORDW-1:0] ty [NUM_SPR];
  logic             tv [NUM_SPR];
  spr_req_t         sb [$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_vcyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attribute RAM: one cycle read latency.
  always @(posedge clk) begin
    attr_y   <= ty[attr_idx];
    attr_vis <= tv[attr_idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    spr_req_t got;
    spr_req_t e;
    if (!reset && rq.req_valid) n_vcyc++;
    if (!reset && rq.req_valid && rq.req_ready) begin
      got.spr = rq.req_spr;
      got.row = rq.req_row;
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      check("req_xfer", 32'(got), 32'(e));
    end
  end

  task automatic clear_table();
    for (int i = 0; i < NUM_SPR; i++) begin
      ty[i] = '0;
      tv[i] = 1'b0;
    end
  endtask

  task automatic push_req(input int spr, input int row);
    spr_req_t r;
    r.spr = SPR_IDXW'(spr);
    r.row = ROWW'(row);
    sb.push_back(r);
  endtask

  task automatic fire_line(input int line);
    @(posedge clk); #1;
    sy = CORDW'(line);
    de = 1'b1;
    @(posedge clk); #1;
    de = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (line_done) begin
        lat = k;
        break;
      end
    end
    if (exp_lat >= 0) check(tag, 32'(lat), 32'(exp_lat));
    else check(tag, 32'(lat >= 0), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rq.req_valid) begin
        found = 1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    reset = 1'b1;
    sy = '0;
    de = 1'b0;
    rq.req_ready = 1'b1;
    clear_table();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_attr_idx", 32'(attr_idx), 32'd0);
    check("rst_req_valid", 32'(rq.req_valid), 32'd0);
    check("rst_req_spr", 32'(rq.req_spr), 32'd0);
    check("rst_req_row", 32'(rq.req_row), 32'd0);
    check("rst_flags", 32'({line_done, overflow, late_err}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // No visible sprites
    v0 = n_vcyc;
    fire_line(100);
    wait_done("t1_latency", 18);
    check("t1_no_valid", 32'(n_vcyc - v0), 32'd0);
    check("t1_overflow", 32'(overflow), 32'd0);

    // Single hit, row = 101 - 95
    ty[3] = 12'd95; tv[3] = 1'b1;
    push_req(3, 6);
    fire_line(100);
    wait_done("t2_latency", 19);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Six hits, only four issued
    clear_table();
    for (int i = 0; i < 6; i++) begin
      ty[i] = 12'd100; tv[i] = 1'b1;
    end
`ifdef SPRITE_SCAN_REV_EN
    for (int i = 5; i >= 2; i--) push_req(i, 1);
`else
    for (int i = 0; i < 4; i++) push_req(i, 1);
`endif
    fire_line(100);
    wait_done("t3_latency", 22);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a request is stalled
    @(posedge clk); #1;
    rq.req_ready = 1'b0;
    fire_line(100);
    wait_valid("rst_mid_valid");
    check("ovf_held", 32'(overflow), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_req_valid", 32'(rq.req_valid), 32'd0);
    check("rst_mid_state", 32'(dut.state), 32'(IDLE));
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rq.req_ready = 1'b1;

    // Last active line prepares line 0; a sprite at 760 must not wrap into it
    clear_table();
    ty[1] = 12'd0;   tv[1] = 1'b1;
    ty[6] = 12'd760; tv[6] = 1'b1;
    push_req(1, 0);
    fire_line(767);
    wait_done("t4_latency", 19);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Stall for five cycles with a late trigger in the middle
    clear_table();
    ty[2] = 12'd100; tv[2] = 1'b1;
    @(posedge clk); #1;
    rq.req_ready = 1'b0;
    push_req(2, 1);
    fire_line(100);
    wait_valid("t5_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t5_stall_valid", 32'(rq.req_valid), 32'd1);
      check("t5_stall_spr", 32'(rq.req_spr), 32'd2);
      check("t5_stall_row", 32'(rq.req_row), 32'd1);
      if (i == 2) check("t5_late_err", 32'(late_err), 32'd1);
      if (i == 3) check("t5_late_pulse", 32'(late_err), 32'd0);
      if (i == 0) de = 1'b1;
      if (i == 1) de = 1'b0;
    end
    @(posedge clk); #1;
    rq.req_ready = 1'b1;
    wait_done("t5_done", -1);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
